// File: rtl/cmul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// cmul_rr_scheduler
//
// Shares one three-stage pipelined Q1.14 complex multiplier among NUM_REQ
// requesters. A round-robin arbiter accepts at most one operation per cycle.
// Each result leaves on a single output channel, tagged with the index of the
// requester that issued it. Results leave in acceptance order.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. A requester holds valid and its
// operands stable until that edge. The output channel holds out_* stable while
// out_valid is high and out_ready is low. req_ready may depend on req_valid.
//
// Ports:
//   clk, rst      single rising-edge clock, synchronous active-high reset
//   req_valid     per-requester operation valid            [NUM_REQ]
//   req_ready     per-requester accept, at most one high   [NUM_REQ]
//   req_real_a    operand A real, slice i = requester i    [NUM_REQ*DATA_WIDTH]
//   req_imag_a    operand A imaginary                      [NUM_REQ*DATA_WIDTH]
//   req_real_b    operand B real                           [NUM_REQ*DATA_WIDTH]
//   req_imag_b    operand B imaginary                      [NUM_REQ*DATA_WIDTH]
//   out_valid     result valid
//   out_ready     downstream accept
//   out_id        requester index of the result            [ID_WIDTH]
//   out_real      saturated real part of A*B               [OUTPUT_WIDTH]
//   out_imag      saturated imaginary part of A*B          [OUTPUT_WIDTH]
//   out_sat       either component was clamped
//   busy          any pipeline stage holds a valid operation
// -----------------------------------------------------------------------------
module cmul_rr_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_WIDTH_F = 14,
  parameter int OUTPUT_WIDTH = DATA_WIDTH,
  parameter int NUM_REQ      = 2,
  parameter int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_real_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_imag_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_real_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_imag_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic [OUTPUT_WIDTH-1:0]       out_real,
  output logic [OUTPUT_WIDTH-1:0]       out_imag,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int PW = 2 * DATA_WIDTH;   // full product width
  localparam int FW = PW + 1;           // sum/difference width, cannot overflow
  localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ID_WIDTH-1:0]            ptr_q, ptr_d;

  logic                           s1_valid_q;
  logic signed [DATA_WIDTH-1:0]   s1_ar_q, s1_ai_q, s1_br_q, s1_bi_q;
  logic [ID_WIDTH-1:0]            s1_id_q;

  logic                           s2_valid_q;
  logic signed [PW-1:0]           s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
  logic [ID_WIDTH-1:0]            s2_id_q;

  logic                           out_valid_q;
  logic [ID_WIDTH-1:0]            out_id_q;
  logic [OUTPUT_WIDTH-1:0]        out_real_q, out_imag_q;
  logic                           out_sat_q;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic stall;
  logic accept;

  // The whole pipeline freezes while the output result is being back-pressured;
  // bubbles are carried through rather than squeezed out.
  assign stall = out_valid_q & ~out_ready;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first valid requester at or above the pointer,
  // wrapping from NUM_REQ-1 back to 0.
  // ---------------------------------------------------------------------------
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH:0]   cand;
  logic [ID_WIDTH:0]   next_ptr;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_WIDTH + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_found && (grant_idx == ID_WIDTH'(i));
    end
  end

  assign req_ready = grant & {NUM_REQ{~stall & ~rst}};
  assign accept    = grant_found & ~stall & ~rst;

  always_comb begin
    next_ptr = {1'b0, grant_idx} + (ID_WIDTH + 1)'(1);
    if (next_ptr >= NUM_REQ_W) next_ptr = '0;
    ptr_d = next_ptr[ID_WIDTH-1:0];
  end

  // Operand mux for the granted requester (grant is one-hot or zero).
  logic [DATA_WIDTH-1:0] sel_ar, sel_ai, sel_br, sel_bi;

  always_comb begin
    sel_ar = '0;
    sel_ai = '0;
    sel_br = '0;
    sel_bi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_ar = req_real_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ai = req_imag_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_br = req_real_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_bi = req_imag_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 products (operands sign-extended to full product width)
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;

  always_comb begin
    ar_x    = {{DATA_WIDTH{s1_ar_q[DATA_WIDTH-1]}}, s1_ar_q};
    ai_x    = {{DATA_WIDTH{s1_ai_q[DATA_WIDTH-1]}}, s1_ai_q};
    br_x    = {{DATA_WIDTH{s1_br_q[DATA_WIDTH-1]}}, s1_br_q};
    bi_x    = {{DATA_WIDTH{s1_bi_q[DATA_WIDTH-1]}}, s1_bi_q};
    prod_rr = ar_x * br_x;
    prod_ii = ai_x * bi_x;
    prod_ri = ar_x * bi_x;
    prod_ir = ai_x * br_x;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: combine, rescale, saturate
  // ---------------------------------------------------------------------------
  // Returns {clamped, value}. The value fits when every bit from the output
  // sign position upward is identical; otherwise clamp by the true sign.
  function automatic logic [OUTPUT_WIDTH:0] saturate(input logic [FW-1:0] v);
    logic [FW-OUTPUT_WIDTH:0] top;
    top = v[FW-1:OUTPUT_WIDTH-1];
    if ((&top) || !(|top)) begin
      return {1'b0, v[OUTPUT_WIDTH-1:0]};
    end else if (v[FW-1]) begin
      return {1'b1, 1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    end
  endfunction

  logic signed [FW-1:0]    re_full, im_full;
  logic signed [FW-1:0]    re_sh, im_sh;
  logic [OUTPUT_WIDTH:0]   re_sat, im_sat;

  always_comb begin
    re_full = {s2_rr_q[PW-1], s2_rr_q} - {s2_ii_q[PW-1], s2_ii_q};
    im_full = {s2_ri_q[PW-1], s2_ri_q} + {s2_ir_q[PW-1], s2_ir_q};
    // Arithmetic shift drops fraction bits toward -inf (floor).
    re_sh   = re_full >>> DATA_WIDTH_F;
    im_sh   = im_full >>> DATA_WIDTH_F;
    re_sat  = saturate(re_sh);
    im_sat  = saturate(im_sh);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_ar_q     <= '0;
      s1_ai_q     <= '0;
      s1_br_q     <= '0;
      s1_bi_q     <= '0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_rr_q     <= '0;
      s2_ii_q     <= '0;
      s2_ri_q     <= '0;
      s2_ir_q     <= '0;
      s2_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      if (accept) ptr_q <= ptr_d;

      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_ar_q <= sel_ar;
          s1_ai_q <= sel_ai;
          s1_br_q <= sel_br;
          s1_bi_q <= sel_bi;
          s1_id_q <= grant_idx;
        end

        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_rr_q <= prod_rr;
          s2_ii_q <= prod_ii;
          s2_ri_q <= prod_ri;
          s2_ir_q <= prod_ir;
          s2_id_q <= s1_id_q;
        end

        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_id_q   <= s2_id_q;
          out_real_q <= re_sat[OUTPUT_WIDTH-1:0];
          out_imag_q <= im_sat[OUTPUT_WIDTH-1:0];
          out_sat_q  <= re_sat[OUTPUT_WIDTH] | im_sat[OUTPUT_WIDTH];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_sat   = out_sat_q;
  assign busy      = s1_valid_q | s2_valid_q | out_valid_q;

endmodule

// File: tb/tb_cmul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cmul_rr_scheduler
//
// Bench for cmul_rr_scheduler with NUM_REQ=2. Requesters are fed from per-
// requester operation queues; a reference model (round-robin pointer plus
// integer complex arithmetic) predicts which requester is accepted each cycle
// and the tagged result, pushing it onto an expected queue. A monitor compares
// every presented output against the head of that queue.
// -----------------------------------------------------------------------------
module tb_cmul_rr_scheduler;

  localparam int NUM_REQ = 2;
  localparam int DW      = 16;
  localparam int IDW     = 1;
  localparam int EXP_W   = IDW + 2*DW + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_real_a, req_imag_a, req_real_b, req_imag_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDW-1:0]        out_id;
  logic [DW-1:0]         out_real, out_imag;
  logic                  out_sat;
  logic                  busy;

  cmul_rr_scheduler #(
    .DATA_WIDTH  (DW),
    .DATA_WIDTH_F(14),
    .OUTPUT_WIDTH(DW),
    .NUM_REQ     (NUM_REQ),
    .ID_WIDTH    (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_real_a(req_real_a),
    .req_imag_a(req_imag_a),
    .req_real_b(req_real_b),
    .req_imag_b(req_imag_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Shared bench state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit lat_mode = 1'b1;   // no backpressure expected: enforce 3-cycle latency

  // Operation word: {a_real, a_imag, b_real, b_imag}
  logic [4*DW-1:0]  pend_q[NUM_REQ][$];
  logic [EXP_W-1:0] exp_q[$];           // {id, real, imag, sat}
  int               acc_q[$];           // acceptance cycle of each expected item

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: exact complex product, floor to Q1.14, clamp to 16 bits
  // ---------------------------------------------------------------------------
  function automatic logic [EXP_W-1:0] model(input logic [4*DW-1:0] op, input int id);
    longint ar, ai, br, bi, re, im;
    logic   s;
    ar = longint'($signed(op[63:48]));
    ai = longint'($signed(op[47:32]));
    br = longint'($signed(op[31:16]));
    bi = longint'($signed(op[15:0]));
    re = ar*br - ai*bi;
    im = ar*bi + ai*br;
    re = re >>> 14;   // floor division by 2^14
    im = im >>> 14;
    s  = 1'b0;
    if (re > 32767)  begin re = 32767;  s = 1'b1; end
    if (re < -32768) begin re = -32768; s = 1'b1; end
    if (im > 32767)  begin im = 32767;  s = 1'b1; end
    if (im < -32768) begin im = -32768; s = 1'b1; end
    return {IDW'(id), 16'(re), 16'(im), s};
  endfunction

  function automatic bit all_pend_empty();
    for (int i = 0; i < NUM_REQ; i++) if (pend_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: presents the head of each requester queue, holding it until the
  // model records its acceptance.
  // ---------------------------------------------------------------------------
  initial begin
    req_valid  = '0;
    req_real_a = '0;
    req_imag_a = '0;
    req_real_b = '0;
    req_imag_b = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend_q[i].size() != 0) begin
          req_valid[i]             = 1'b1;
          req_real_a[i*DW +: DW]   = pend_q[i][0][63:48];
          req_imag_a[i*DW +: DW]   = pend_q[i][0][47:32];
          req_real_b[i*DW +: DW]   = pend_q[i][0][31:16];
          req_imag_b[i*DW +: DW]   = pend_q[i][0][15:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic push_op(input int req, input logic [4*DW-1:0] op);
    pend_q[req].push_back(op);
  endtask

  // ---------------------------------------------------------------------------
  // Acceptance model: predicts req_ready each cycle and enqueues results
  // ---------------------------------------------------------------------------
  initial begin
    int               ptr_m;
    int               g;
    int               idx;
    bit               stall_m;
    logic [NUM_REQ-1:0] exp_rdy;
    ptr_m = 0;
    forever begin
      @(negedge clk);
      exp_rdy = '0;
      g       = -1;
      stall_m = out_valid && !out_ready;
      if (!rst && !stall_m) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (ptr_m + k) % NUM_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL req_ready cycle %0d: got %b expected %b", cycle, req_ready, exp_rdy);
      end
      if (rst) begin
        ptr_m = 0;
        exp_q.delete();
        acc_q.delete();
      end else if (g >= 0) begin
        exp_q.push_back(model(pend_q[g].pop_front(), g));
        acc_q.push_back(cycle);
        ptr_m = (g + 1) % NUM_REQ;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    bit               front_seen;
    logic [EXP_W-1:0] got;
    front_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        front_seen = 1'b0;
      end else if (out_valid) begin
        got = {out_id, out_real, out_imag, out_sat};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cycle %0d: got %h with nothing expected", cycle, got);
        end else begin
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL result cycle %0d: got id=%0d re=%h im=%h sat=%b expected id=%0d re=%h im=%h sat=%b",
                     cycle, got[EXP_W-1 -: IDW], got[32:17], got[16:1], got[0],
                     exp_q[0][EXP_W-1 -: IDW], exp_q[0][32:17], exp_q[0][16:1], exp_q[0][0]);
          end
          if (!front_seen) begin
            front_seen = 1'b1;
            if (lat_mode) begin
              checks++;
              if (cycle - acc_q[0] != 3) begin
                errors++;
                $display("FAIL latency cycle %0d: got %0d expected 3", cycle, cycle - acc_q[0]);
              end
            end
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((!all_pend_empty() || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: %0d ops still outstanding after %0d cycles", name, exp_q.size(), budget);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DW-1:0] rand_op();
    logic [4*DW-1:0] op;
    if ($urandom_range(0, 1) == 0) begin
      op = {$urandom(), $urandom()};
    end else begin
      op[63:48] = 16'($signed($urandom_range(0, 8192)) - 4096);
      op[47:32] = 16'($signed($urandom_range(0, 8192)) - 4096);
      op[31:16] = 16'($signed($urandom_range(0, 8192)) - 4096);
      op[15:0]  = 16'($signed($urandom_range(0, 8192)) - 4096);
    end
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_busy",      64'(busy),      64'd0);
    check_val("reset_out_data",  {out_id, out_real, out_imag, out_sat}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed single operations on requester 0
    lat_mode = 1'b1;
    push_op(0, {16'h2000, 16'h2000, 16'h2000, 16'hE000});
    wait_idle("single", 20);
    push_op(0, {16'h6000, 16'h6000, 16'h6000, 16'hA000});
    wait_idle("sat_pos", 20);
    push_op(0, {16'h8000, 16'h0000, 16'h8000, 16'h0000});
    wait_idle("sat_min", 20);
    push_op(0, {16'h0001, 16'h0000, 16'hFFFF, 16'h0000});
    wait_idle("trunc", 20);

    // Reset while two operations are in flight
    push_op(0, rand_op());
    push_op(1, rand_op());
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!all_pend_empty() && n < 20);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("midreset_out_valid", 64'(out_valid), 64'd0);
    check_val("midreset_busy",      64'(busy),      64'd0);
    check_val("midreset_out_data",  {out_id, out_real, out_imag, out_sat}, 64'd0);
    repeat (5) @(negedge clk);
    check_val("midreset_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Round-robin: both requesters valid for 8 accepts; pointer starts at 0
    for (int i = 0; i < 4; i++) begin
      push_op(0, rand_op());
      push_op(1, rand_op());
    end
    wait_idle("round_robin", 40);

    // Backpressure mid-stream
    lat_mode = 1'b0;
    for (int i = 0; i < 6; i++) push_op(0, rand_op());
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("backpressure", 40);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NUM_REQ; r++) begin
        if ($urandom_range(0, 2) != 0 && pend_q[r].size() < 3) push_op(r, rand_op());
      end
    end
    out_ready = 1'b1;
    wait_idle("random", 2000);
    check_val("final_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmul_rr_scheduler.md
Name: cmul_rr_scheduler

Overview:
- Time-shares one pipelined Q1.14 complex multiplier among NUM_REQ requesters in the OFDM datapath (e.g. pilot phase rotation, equalizer, CFO de-rotation).
- Arbitrates requests round-robin and accepts at most one operation per cycle.
- Returns each result tagged with the requester index, over a single valid/ready output channel with backpressure.

Parameters:
- DATA_WIDTH, 16, width of each signed operand component.
- DATA_WIDTH_F, 14, fractional bits of operands and result (Q1.14).
- OUTPUT_WIDTH, DATA_WIDTH, width of each result component.
- NUM_REQ, 2, number of requesters (2..8).
- ID_WIDTH, max(1,$clog2(NUM_REQ)), width of the requester tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_real_a  in  NUM_REQ*DATA_WIDTH  operand A real; slice i belongs to requester i.
- req_imag_a  in  NUM_REQ*DATA_WIDTH  operand A imaginary.
- req_real_b  in  NUM_REQ*DATA_WIDTH  operand B real.
- req_imag_b  in  NUM_REQ*DATA_WIDTH  operand B imaginary.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_id  out  ID_WIDTH  index of the requester that issued the result.
- out_real  out  OUTPUT_WIDTH  signed real part of A*B.
- out_imag  out  OUTPUT_WIDTH  signed imaginary part of A*B.
- out_sat  out  1  either component saturated.
- busy  out  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - Clears all stage valids, data/tag registers and out_* to 0.
  - Sets the round-robin pointer to 0.
  - req_ready is 0 while rst is high.
  - Reset mid-operation drops all in-flight operations; no stale result appears afterwards.
- Stall: stall = out_valid & ~out_ready. While stalled, every pipeline register holds its value. Bubbles are not collapsed.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i], searching from pointer upward with wrap at NUM_REQ-1 -> 0.
  - req_ready[i] = grant[i] & ~stall & ~rst. req_ready may depend on req_valid.
  - Handshake occurs when req_valid[i] & req_ready[i].
  - After a handshake, pointer <= granted index + 1 (mod NUM_REQ). Otherwise pointer holds.
  - Requesters must hold operands stable while valid and not ready.
- Pipeline:
  - Stage 1: capture operands and tag on handshake.
  - Stage 2: register the four full-width products rr, ii, ri, ir (2*DATA_WIDTH each).
  - Stage 3: real = rr-ii and imag = ri+ir at 2*DATA_WIDTH+1 bits; arithmetic shift right by DATA_WIDTH_F (truncation toward -inf); saturate to OUTPUT_WIDTH; register into out_*.
- Latency: handshake in cycle t -> out_valid in cycle t+3 when no stall. Throughput is 1 op/cycle.
- Saturation:
  - A component above 2^(OUTPUT_WIDTH-1)-1 clamps to 0x7FFF.
  - A component below -2^(OUTPUT_WIDTH-1) clamps to 0x8000.
  - out_sat = 1 if either component clamped; out_sat is registered alongside the data.
- Output hold: out_* stays stable while out_valid & ~out_ready. The result retires on out_valid & out_ready.
- Simultaneous events: a stage-3 retire and a stage-1 accept in the same cycle are both legal. Ordering is strictly FIFO by acceptance.
- busy = OR of the three stage valids.

Test Plan:
- Single op: requester 0, A=(0x2000,0x2000), B=(0x2000,0xE000), out_ready=1 -> out_valid exactly 3 cycles after handshake; out_real=0x2000, out_imag=0x0000, out_id=0, out_sat=0.
- Saturation: A=(0x6000,0x6000), B=(0x6000,0xA000) -> out_real=0x7FFF, out_imag=0x0000, out_sat=1. Then A=(0x8000,0), B=(0x8000,0) -> out_real=0x7FFF, out_sat=1.
- Truncation: A=(0x0001,0), B=(0xFFFF,0) -> out_real=0xFFFF, out_imag=0xFFFF? No: out_imag=0x0000. Confirms floor rounding of real part.
- Round-robin: NUM_REQ=2, both valid for 8 cycles with distinct operands -> grants 0,1,0,1,...; one accept per cycle; out_id alternates; all 8 results correct and in order.
- Backpressure: stream 6 ops, drop out_ready for 5 cycles mid-stream -> req_ready all 0 and out_* frozen during the stall; after release all 6 results arrive exactly once, in order.
- Reset mid-flight: accept 2 ops, assert rst one cycle before first output -> out_valid=0 and busy=0 after reset; pointer=0 (next grant to requester 0 when both valid); no stale result appears.
